// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types, funct3 codes and op legality check for the memory stage
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      EXC_NONE       = 2'b00,
      EXC_MISALIGNED = 2'b01,
      EXC_ILLEGAL    = 2'b10,
      EXC_TIMEOUT    = 2'b11
   } exc_cause_e;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;
   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mem_bus_req_t;

   // Illegal encodings take priority over alignment faults.
   function automatic exc_cause_e check_op(input logic rd, input logic wr,
                                           input logic [2:0] f3, input logic [1:0] a);
      if ((rd && wr) || f3 == 3'b011 || f3[2:1] == 2'b11 || (wr && f3 > FUNCT3_SW))
         return EXC_ILLEGAL;
      if ((f3[1:0] == 2'b01 && a[0]) || (f3 == FUNCT3_LW && a != 2'b00))
         return EXC_MISALIGNED;
      return EXC_NONE;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align_ext.sv
// rtl/mem_access_unit_load_align_ext.sv - load lane select and sign/zero extension
module mem_access_unit_load_align_ext
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [31:0] lane;

   assign lane = rdata_i >> {off_i, 3'b000};

   always_comb begin
      data_o = lane;
      case (funct3_i)
         FUNCT3_LB:  data_o = {{24{lane[7]}}, lane[7:0]};
         FUNCT3_LH:  data_o = {{16{lane[15]}}, lane[15:0]};
         FUNCT3_LBU: data_o = {24'd0, lane[7:0]};
         FUNCT3_LHU: data_o = {16'd0, lane[15:0]};
         default:    data_o = lane;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store stage driving a req/gnt/rvalid data bus
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned pMaxWait = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] op_addr_i,
   input  logic [31:0] op_data_i,
   input  logic [4:0]  op_rd_addr_i,
   input  logic [2:0]  op_funct3_i,
   input  logic        op_read_i,
   input  logic        op_write_i,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [4:0]  wb_addr_o,
   output logic [31:0] wb_data_o,
   output logic        wb_dv_o,
   output logic        exc_valid_o,
   output logic [1:0]  exc_cause_o,
   output logic [31:0] exc_addr_o
);

   localparam int unsigned CntW = $clog2(pMaxWait);
   localparam logic [CntW-1:0] CntLast = CntW'(pMaxWait - 1);

   lsu_state_e   state_q, state_d;
   mem_bus_req_t bus_q, bus_d;
   logic [1:0]   off_q, off_d;
   logic [2:0]   funct3_q, funct3_d;
   logic [4:0]   rd_q, rd_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [4:0]   wb_addr_q, wb_addr_d;
   logic [31:0]  wb_data_q, wb_data_d;
   logic         wb_dv_q, wb_dv_d;
   logic         exc_valid_q, exc_valid_d;
   logic [1:0]   exc_cause_q, exc_cause_d;
   logic [31:0]  exc_addr_q, exc_addr_d;

   exc_cause_e   op_cause;
   logic [3:0]   store_be;
   logic [31:0]  store_wdata;
   logic [31:0]  load_data;

   assign op_cause = check_op(op_read_i, op_write_i, op_funct3_i, op_addr_i[1:0]);

   always_comb begin
      store_be    = 4'b1111;
      store_wdata = op_data_i;
      case (op_funct3_i)
         FUNCT3_SB: begin
            store_be    = 4'b0001 << op_addr_i[1:0];
            store_wdata = {4{op_data_i[7:0]}};
         end
         FUNCT3_SH: begin
            store_be    = 4'b0011 << op_addr_i[1:0];
            store_wdata = {2{op_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   mem_access_unit_load_align_ext u_load_align_ext (
      .rdata_i  (mem_rdata_i),
      .off_i    (off_q),
      .funct3_i (funct3_q),
      .data_o   (load_data)
   );

   always_comb begin
      state_d     = state_q;
      bus_d       = bus_q;
      off_d       = off_q;
      funct3_d    = funct3_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      wb_dv_d     = 1'b0;
      exc_valid_d = 1'b0;
      exc_cause_d = exc_cause_q;
      exc_addr_d  = exc_addr_q;
      case (state_q)
         LSU_IDLE: begin
            if (op_read_i || op_write_i) begin
               if (op_cause != EXC_NONE) begin
                  exc_valid_d = 1'b1;
                  exc_cause_d = op_cause;
                  exc_addr_d  = op_addr_i;
               end else begin
                  state_d     = LSU_REQ;
                  bus_d.req   = 1'b1;
                  bus_d.we    = op_write_i;
                  bus_d.addr  = {op_addr_i[31:2], 2'b00};
                  bus_d.be    = store_be;
                  bus_d.wdata = store_wdata;
                  off_d       = op_addr_i[1:0];
                  funct3_d    = op_funct3_i;
                  rd_d        = op_rd_addr_i;
                  cnt_d       = '0;
               end
            end
         end
         LSU_REQ: begin
            if (mem_gnt_i) begin
               bus_d.req = 1'b0;
               state_d   = bus_q.we ? LSU_IDLE : LSU_WAIT;
               cnt_d     = '0;
            end else if (cnt_q == CntLast) begin
               bus_d.req   = 1'b0;
               state_d     = LSU_IDLE;
               exc_valid_d = 1'b1;
               exc_cause_d = EXC_TIMEOUT;
               exc_addr_d  = {bus_q.addr[31:2], off_q};
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LSU_WAIT: begin
            // A late rvalid in the final counted cycle still completes the load.
            if (mem_rvalid_i) begin
               wb_addr_d = rd_q;
               wb_data_d = load_data;
               wb_dv_d   = (rd_q != 5'd0);
               state_d   = LSU_IDLE;
            end else if (cnt_q == CntLast) begin
               state_d     = LSU_IDLE;
               exc_valid_d = 1'b1;
               exc_cause_d = EXC_TIMEOUT;
               exc_addr_d  = {bus_q.addr[31:2], off_q};
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= LSU_IDLE;
         bus_q       <= '0;
         off_q       <= 2'd0;
         funct3_q    <= 3'd0;
         rd_q        <= 5'd0;
         cnt_q       <= '0;
         wb_addr_q   <= 5'd0;
         wb_data_q   <= 32'd0;
         wb_dv_q     <= 1'b0;
         exc_valid_q <= 1'b0;
         exc_cause_q <= 2'd0;
         exc_addr_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         bus_q       <= bus_d;
         off_q       <= off_d;
         funct3_q    <= funct3_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
         wb_dv_q     <= wb_dv_d;
         exc_valid_q <= exc_valid_d;
         exc_cause_q <= exc_cause_d;
         exc_addr_q  <= exc_addr_d;
      end
   end

   assign stall_o     = (state_q != LSU_IDLE);
   assign mem_req_o   = bus_q.req;
   assign mem_we_o    = bus_q.we;
   assign mem_addr_o  = bus_q.addr;
   assign mem_be_o    = bus_q.be;
   assign mem_wdata_o = bus_q.wdata;
   assign wb_addr_o   = wb_addr_q;
   assign wb_data_o   = wb_data_q;
   assign wb_dv_o     = wb_dv_q;
   assign exc_valid_o = exc_valid_q;
   assign exc_cause_o = exc_cause_q;
   assign exc_addr_o  = exc_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] op_addr, op_data;
   logic [4:0]  op_rd;
   logic [2:0]  op_f3;
   logic        op_read, op_write;
   logic        gnt, rvalid;
   logic [31:0] rdata;
   logic        stall, req, we, wb_dv, exc_valid;
   logic [31:0] maddr, wdata, wb_data, exc_addr;
   logic [3:0]  be;
   logic [4:0]  wb_addr;
   logic [1:0]  exc_cause;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.pMaxWait(64)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .op_addr_i    (op_addr),
      .op_data_i    (op_data),
      .op_rd_addr_i (op_rd),
      .op_funct3_i  (op_f3),
      .op_read_i    (op_read),
      .op_write_i   (op_write),
      .stall_o      (stall),
      .mem_req_o    (req),
      .mem_we_o     (we),
      .mem_addr_o   (maddr),
      .mem_be_o     (be),
      .mem_wdata_o  (wdata),
      .mem_gnt_i    (gnt),
      .mem_rvalid_i (rvalid),
      .mem_rdata_i  (rdata),
      .wb_addr_o    (wb_addr),
      .wb_data_o    (wb_data),
      .wb_dv_o      (wb_dv),
      .exc_valid_o  (exc_valid),
      .exc_cause_o  (exc_cause),
      .exc_addr_o   (exc_addr)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference rules expressed as access sizes and modular arithmetic.
   function automatic int unsigned access_size(input logic [2:0] f3);
      int unsigned w;
      w = f3 % 4;
      return (w == 0) ? 1 : (w == 1) ? 2 : 4;
   endfunction

   function automatic logic [1:0] ref_cause(input logic r, input logic w,
                                            input logic [2:0] f3, input logic [31:0] a);
      if (r && w) return 2'd2;
      if (f3 == 3 || f3 == 6 || f3 == 7) return 2'd2;
      if (w && f3 > 2) return 2'd2;
      if (a % access_size(f3) != 0) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                            input logic [2:0] f3);
      logic [31:0] v;
      v = word >> ((a % 4) * 8);
      case (f3)
         3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
         3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
         3'd4: v = v % 256;
         3'd5: v = v % 65536;
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      int unsigned n;
      n = access_size(f3);
      return 4'(((1 << n) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (access_size(f3))
         1:       return (d % 256) * 32'h0101_0101;
         2:       return (d % 65536) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   task automatic present(input logic r, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
      op_read = r; op_write = w; op_f3 = f3; op_addr = a; op_data = d; op_rd = rd;
   endtask

   task automatic clear_op();
      op_read = 1'b0; op_write = 1'b0; op_addr = '0; op_data = '0; op_rd = '0; op_f3 = '0;
   endtask

   // Starts and ends on a falling edge; the op is presented for exactly one cycle.
   task automatic run_op(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input int gdly, input int vdly, input logic [31:0] word,
                         input logic junk_rv);
      logic [1:0] cause;
      int req_cycles;
      cause = ref_cause(r, w, f3, a);
      present(r, w, f3, a, d, rd);
      @(negedge clk);
      clear_op();
      if (cause != 2'd0) begin
         check_eq("exc_valid", exc_valid, 1'b1);
         check_eq("exc_cause", exc_cause, cause);
         check_eq("exc_addr", exc_addr, a);
         check_eq("exc_no_req", req, 1'b0);
         check_eq("exc_no_stall", stall, 1'b0);
         return;
      end
      check_eq("acc_exc", exc_valid, 1'b0);
      check_eq("acc_addr", maddr, {a[31:2], 2'b00});
      check_eq("acc_we", we, w);
      if (w) begin
         check_eq("st_be", be, ref_be(f3, a));
         check_eq("st_wdata", wdata, ref_wdata(f3, d));
      end
      req_cycles = 0;
      for (int i = 0; i <= gdly; i++) begin
         if (req && stall) req_cycles++;
         if (i == gdly) begin
            gnt = 1'b1;
            rvalid = junk_rv;
            rdata = ~word;
         end
         @(negedge clk);
         gnt = 1'b0;
         rvalid = 1'b0;
      end
      check_eq("req_cycles", req_cycles, gdly + 1);
      check_eq("post_gnt_req", req, 1'b0);
      if (w) begin
         check_eq("st_done_stall", stall, 1'b0);
         check_eq("st_no_dv", wb_dv, 1'b0);
         return;
      end
      check_eq("ld_wait_stall", stall, 1'b1);
      for (int i = 0; i < vdly; i++) begin
         gnt = 1'($urandom_range(0, 1));
         @(negedge clk);
         gnt = 1'b0;
      end
      rvalid = 1'b1;
      rdata = word;
      @(negedge clk);
      rvalid = 1'b0;
      check_eq("ld_dv", wb_dv, rd != 5'd0);
      if (rd != 5'd0) begin
         check_eq("ld_wb_addr", wb_addr, rd);
         check_eq("ld_wb_data", wb_data, ref_load(word, a, f3));
      end
      check_eq("ld_done_stall", stall, 1'b0);
      check_eq("ld_no_exc", exc_valid, 1'b0);
   endtask

   // Withholds gnt (store) or rvalid (load) and expects a timeout after 64 cycles.
   task automatic timeout_case(input logic w, input logic [31:0] a);
      int cnt;
      present(!w, w, 3'd2, a, 32'h5555_AAAA, 5'd9);
      @(negedge clk);
      clear_op();
      if (!w) begin
         gnt = 1'b1;
         @(negedge clk);
         gnt = 1'b0;
      end
      cnt = 0;
      while (stall && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      check_eq(w ? "to_req_cycles" : "to_wait_cycles", cnt, 64);
      check_eq("to_exc_valid", exc_valid, 1'b1);
      check_eq("to_exc_cause", exc_cause, 2'd3);
      check_eq("to_exc_addr", exc_addr, a);
      check_eq("to_no_req", req, 1'b0);
      rvalid = 1'b1;
      rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("to_late_rvalid_dv", wb_dv, 1'b0);
         check_eq("to_exc_pulse", exc_valid, 1'b0);
      end
      rvalid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_stall"}, stall, 1'b0);
      check_eq({tag, "_req"}, req, 1'b0);
      check_eq({tag, "_we"}, we, 1'b0);
      check_eq({tag, "_addr"}, maddr, 32'd0);
      check_eq({tag, "_be"}, be, 4'd0);
      check_eq({tag, "_wdata"}, wdata, 32'd0);
      check_eq({tag, "_wb_addr"}, wb_addr, 5'd0);
      check_eq({tag, "_wb_data"}, wb_data, 32'd0);
      check_eq({tag, "_wb_dv"}, wb_dv, 1'b0);
      check_eq({tag, "_exc"}, {exc_valid, exc_cause}, 3'd0);
      check_eq({tag, "_exc_addr"}, exc_addr, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      logic [2:0]  f3;
      logic        r, w;
      int          sel;
      rst = 1'b1;
      gnt = 1'b0;
      rvalid = 1'b0;
      rdata = '0;
      clear_op();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      run_op(1, 0, 3'd0, 32'h103, 32'h0, 5'd5, 0, 0, 32'h80FF_1234, 0);
      check_eq("lb_sext_const", wb_data, 32'hFFFF_FF80);
      run_op(0, 1, 3'd1, 32'h202, 32'hABCD, 5'd0, 3, 0, 32'h0, 0);
      run_op(1, 0, 3'd2, 32'h101, 32'h0, 5'd3, 0, 0, 32'h0, 0);
      run_op(1, 0, 3'd2, 32'h100, 32'h0, 5'd7, 0, 0, 32'hCAFE_F00D, 0);
      run_op(1, 0, 3'd2, 32'h400, 32'h0, 5'd0, 1, 2, 32'h1234_5678, 1);
      @(negedge clk);
      check_eq("rd0_no_dv", wb_dv, 1'b0);
      timeout_case(0, 32'h0000_0800);
      timeout_case(1, 32'h0000_0C04);

      present(1, 0, 3'd2, 32'h40, 32'h0, 5'd4);
      @(negedge clk);
      clear_op();
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("midrst");
      rvalid = 1'b1;
      rdata = 32'h7777_7777;
      @(negedge clk);
      rvalid = 1'b0;
      check_eq("midrst_late_dv", wb_dv, 1'b0);
      check_eq("midrst_stall", stall, 1'b0);
      @(negedge clk);
      check_eq("midrst_late_dv2", wb_dv, 1'b0);

      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 9);
         r = (sel <= 5);
         w = (sel == 0) || (sel >= 6);
         f3 = 3'($urandom_range(0, 7));
         run_op(r, w, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
